// File: rtl/lfsr6_pkg.sv
// lfsr6_pkg
// Shared definitions for the 6-bit, 3-bits-per-clock XNOR PRBS family
// (recurrence s[n] = s[n-5] XNOR s[n-6], period 63).
//   LFSR_W       : history / generator state width
//   STEP         : stream bits carried per word
//   LOCKUP       : all-ones state an XNOR register can never leave
//   sync_state_t : checker synchronisation states (codes are externally visible)
//   popcount3    : number of set bits in a 3-bit word
package lfsr6_pkg;

   localparam int unsigned LFSR_W = 6;
   localparam int unsigned STEP   = 3;

   localparam logic [LFSR_W-1:0] LOCKUP = 6'h3F;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } sync_state_t;

   function automatic logic [1:0] popcount3(input logic [STEP-1:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/lfsr6_step3.sv
// lfsr6_step3
// Combinational predictor: given the last 6 stream bits, produce the next 3
// bits of the XNOR PRBS and the history that results from appending them.
// Ports:
//   state      in  [5:0]  last 6 stream bits, state[5] oldest (h6), state[0] newest (h1)
//   pred       out [2:0]  next 3 bits, pred[2] first in time
//   next_state out [5:0]  state shifted by 3 with pred appended
module lfsr6_step3
   import lfsr6_pkg::*;
(
   input  logic [LFSR_W-1:0] state,
   output logic [STEP-1:0]   pred,
   output logic [LFSR_W-1:0] next_state
);

   // state[i] is h[i+1]; each new bit is h[n-5] XNOR h[n-6] relative to its own position
   always_comb begin
      pred[2]    = state[4] ~^ state[5];
      pred[1]    = state[3] ~^ state[4];
      pred[0]    = state[2] ~^ state[3];
      next_state = {state[2:0], pred};
   end

endmodule

// File: rtl/lfsr6s3_chk.sv
// lfsr6s3_chk
// Receive-side checker for the 6-bit, 3-bits-per-clock XNOR PRBS stream.
// Self-synchronises to incoming words, declares lock after LOCK_CNT clean
// words, then flywheels its own predictor and counts bit errors.
// Parameters:
//   LOCK_CNT   consecutive clean words in VERIFY needed to lock (>=1)
//   UNLOCK_CNT consecutive errored words in LOCKED that drop lock (>=1)
//   CNT_W      width of the saturating bit-error counter (>=2)
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   din_valid  in   din carries a new word this cycle
//   din        in   [2:0] received word, din[2] oldest bit
//   err_clr    in   synchronous clear of err_cnt
//   locked     out  checker is in LOCKED
//   err_word   out  one-cycle pulse, last LOCKED word had >=1 bit error
//   err_cnt    out  [CNT_W-1:0] saturating count of bit errors seen in LOCKED
//   sync_state out  [1:0] FILL=0, VERIFY=1, LOCKED=2
module lfsr6s3_chk
   import lfsr6_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter int unsigned CNT_W      = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             din_valid,
   input  logic [STEP-1:0]  din,
   input  logic             err_clr,
   output logic             locked,
   output logic             err_word,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       sync_state
);

   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
   localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

   sync_state_t       state, state_n;
   logic [LFSR_W-1:0] h, h_n;
   logic              fill_cnt, fill_n;
   logic [GOOD_W-1:0] good_cnt, good_n;
   logic [BAD_W-1:0]  bad_cnt, bad_n;
   logic              err_word_n;
   logic [CNT_W-1:0]  cnt_n;

   logic [STEP-1:0]   pred;
   logic [LFSR_W-1:0] h_fly;
   logic [STEP-1:0]   mism;
   logic [1:0]        bit_errs;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W:0]    cnt_sum;

   lfsr6_step3 u_step (
      .state      (h),
      .pred       (pred),
      .next_state (h_fly)
   );

   assign mism     = din ^ pred;
   assign bit_errs = popcount3(mism);

   // A clear coinciding with a counted word applies first, so that word's errors survive
   assign cnt_base = err_clr ? '0 : err_cnt;
   // e <= 3 and CNT_W >= 2, so any overflow shows up in the extra carry bit
   assign cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(bit_errs);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FILL;
         h        <= '0;
         fill_cnt <= 1'b0;
         good_cnt <= '0;
         bad_cnt  <= '0;
         err_word <= 1'b0;
         err_cnt  <= '0;
      end else begin
         state    <= state_n;
         h        <= h_n;
         fill_cnt <= fill_n;
         good_cnt <= good_n;
         bad_cnt  <= bad_n;
         err_word <= err_word_n;
         err_cnt  <= cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      h_n        = h;
      fill_n     = fill_cnt;
      good_n     = good_cnt;
      bad_n      = bad_cnt;
      err_word_n = 1'b0;
      cnt_n      = err_clr ? '0 : err_cnt;

      if (din_valid) begin
         unique case (state)
            FILL: begin
               h_n = {h[2:0], din};
               if (fill_cnt) begin
                  state_n = VERIFY;
                  fill_n  = 1'b0;
                  good_n  = '0;
               end else begin
                  fill_n  = 1'b1;
               end
            end

            VERIFY: begin
               h_n = {h[2:0], din};
               // a matching word out of the all-ones history proves nothing
               if (mism == '0 && h != LOCKUP) begin
                  if (good_cnt == GOOD_LAST) begin
                     state_n = LOCKED;
                     good_n  = '0;
                     bad_n   = '0;
                  end else begin
                     good_n  = good_cnt + GOOD_W'(1);
                  end
               end else begin
                  good_n = '0;
               end
            end

            LOCKED: begin
               // flywheel: received data never enters the history
               h_n        = h_fly;
               err_word_n = |mism;
               cnt_n      = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
               if (|mism) begin
                  if (bad_cnt == BAD_LAST) begin
                     state_n = FILL;
                     bad_n   = '0;
                     fill_n  = 1'b0;
                  end else begin
                     bad_n   = bad_cnt + BAD_W'(1);
                  end
               end else begin
                  bad_n = '0;
               end
            end

            default: begin
               state_n = FILL;
               fill_n  = 1'b0;
               good_n  = '0;
               bad_n   = '0;
            end
         endcase
      end
   end

   assign locked     = (state == LOCKED);
   assign sync_state = state;

endmodule

// File: tb/tb_lfsr6s3_chk.sv
// tb_lfsr6s3_chk
// Directed bench for lfsr6s3_chk: one instance with default parameters and one
// with CNT_W=4 / UNLOCK_CNT=255 for saturation. Expected outputs are queued when
// a word is driven and compared after the clock edge that samples it.
module tb_lfsr6s3_chk;

   logic        clk;
   logic        reset;

   logic        a_valid, a_clr;
   logic [2:0]  a_din;
   logic        a_locked, a_err_word;
   logic [15:0] a_cnt;
   logic [1:0]  a_state;

   logic        b_valid, b_clr;
   logic [2:0]  b_din;
   logic        b_locked, b_err_word;
   logic [3:0]  b_cnt;
   logic [1:0]  b_state;

   lfsr6s3_chk #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .din_valid  (a_valid),
      .din        (a_din),
      .err_clr    (a_clr),
      .locked     (a_locked),
      .err_word   (a_err_word),
      .err_cnt    (a_cnt),
      .sync_state (a_state)
   );

   lfsr6s3_chk #(.LOCK_CNT(4), .UNLOCK_CNT(255), .CNT_W(4)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .din_valid  (b_valid),
      .din        (b_din),
      .err_clr    (b_clr),
      .locked     (b_locked),
      .err_word   (b_err_word),
      .err_cnt    (b_cnt),
      .sync_state (b_state)
   );

   typedef struct {
      bit          sel;
      logic        locked;
      logic        err_word;
      logic [15:0] cnt;
      logic [1:0]  state;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [5:0]  gen_a, gen_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   // next 3 bits straight from the recurrence, s[8] oldest
   function automatic logic [2:0] next_word(input logic [5:0] g);
      logic [8:0] s;
      s = {g, 3'b000};
      for (int i = 2; i >= 0; i--) s[i] = s[i+5] ~^ s[i+6];
      return s[2:0];
   endfunction

   // expected sync state after the k-th valid clean word from a fresh start
   function automatic logic [1:0] st(input int k);
      return (k < 2) ? 2'd0 : (k < 6) ? 2'd1 : 2'd2;
   endfunction

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input bit sel, input logic [1:0] es, input logic ew, input int ec);
      exp_t x;
      x.sel      = sel;
      x.state    = es;
      x.locked   = (es == 2'd2);
      x.err_word = ew;
      x.cnt      = 16'(ec);
      sb.push_back(x);
   endtask

   task automatic check_out();
      exp_t x;
      x = sb.pop_front();
      if (x.sel == 1'b0) begin
         cmp("a_locked",     16'(a_locked),   16'(x.locked));
         cmp("a_err_word",   16'(a_err_word), 16'(x.err_word));
         cmp("a_err_cnt",    a_cnt,           x.cnt);
         cmp("a_sync_state", 16'(a_state),    16'(x.state));
      end else begin
         cmp("b_locked",     16'(b_locked),   16'(x.locked));
         cmp("b_err_word",   16'(b_err_word), 16'(x.err_word));
         cmp("b_err_cnt",    16'(b_cnt),      x.cnt);
         cmp("b_sync_state", 16'(b_state),    16'(x.state));
      end
   endtask

   task automatic step(input bit sel, input bit valid, input logic [2:0] d, input bit clr,
                       input logic [1:0] es, input logic ew, input int ec);
      @(negedge clk);
      a_valid = 1'b0; a_clr = 1'b0; a_din = 3'b000;
      b_valid = 1'b0; b_clr = 1'b0; b_din = 3'b000;
      if (sel == 1'b0) begin
         a_valid = valid; a_din = d; a_clr = clr;
      end else begin
         b_valid = valid; b_din = d; b_clr = clr;
      end
      push_exp(sel, es, ew, ec);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // one generator word (optionally corrupted by mask) into the selected DUT
   task automatic word(input bit sel, input logic [2:0] mask, input bit clr,
                       input logic [1:0] es, input logic ew, input int ec);
      logic [2:0] d;
      if (sel == 1'b0) begin
         d = next_word(gen_a);
         gen_a = {gen_a[2:0], d};
      end else begin
         d = next_word(gen_b);
         gen_b = {gen_b[2:0], d};
      end
      step(sel, 1'b1, d ^ mask, clr, es, ew, ec);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      a_valid = 1'b0; a_clr = 1'b0;
      b_valid = 1'b0; b_clr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      gen_a = '0;
      gen_b = '0;
   endtask

   initial begin
      int k;
      reset = 1'b1;
      a_valid = 1'b0; a_clr = 1'b0; a_din = 3'b000;
      b_valid = 1'b0; b_clr = 1'b0; b_din = 3'b000;
      gen_a = '0;
      gen_b = '0;

      // reset state of both instances
      repeat (3) @(posedge clk);
      #1;
      push_exp(1'b0, 2'd0, 1'b0, 0);
      check_out();
      push_exp(1'b1, 2'd0, 1'b0, 0);
      check_out();
      @(negedge clk);
      reset = 1'b0;

      // clean continuous stream: lock on word 6, 500 words without errors
      for (int i = 1; i <= 500; i++) word(1'b0, 3'b000, 1'b0, st(i), 1'b0, 0);

      // single flipped middle bit: one-cycle pulse, no propagation
      word(1'b0, 3'b010, 1'b0, 2'd2, 1'b1, 1);
      for (int i = 0; i < 5; i++) word(1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 1);

      // clear on a clean counted word, then three inverted words drop lock
      word(1'b0, 3'b000, 1'b1, 2'd2, 1'b0, 0);
      word(1'b0, 3'b111, 1'b0, 2'd2, 1'b1, 3);
      word(1'b0, 3'b111, 1'b0, 2'd2, 1'b1, 6);
      word(1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 9);
      for (int i = 1; i <= 6; i++) word(1'b0, 3'b000, 1'b0, st(i), 1'b0, 9);
      for (int i = 0; i < 3; i++) word(1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 9);

      // stuck all-ones input never locks
      do_reset();
      for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 3'b111, 1'b0, (i < 2) ? 2'd0 : 2'd1, 1'b0, 0);

      // valid every other cycle with garbage on idle cycles: lock on the 6th valid word
      do_reset();
      k = 0;
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) begin
            k++;
            word(1'b0, 3'b000, 1'b0, st(k), 1'b0, 0);
         end else begin
            step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0, st(k), 1'b0, 0);
         end
      end

      // build err_cnt=7 while staying locked, then asynchronous reset
      word(1'b0, 3'b111, 1'b0, 2'd2, 1'b1, 3);
      word(1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 3);
      word(1'b0, 3'b111, 1'b0, 2'd2, 1'b1, 6);
      word(1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 6);
      word(1'b0, 3'b001, 1'b0, 2'd2, 1'b1, 7);
      word(1'b0, 3'b000, 1'b0, 2'd2, 1'b0, 7);
      a_valid = 1'b0;
      reset = 1'b1;
      #2;
      push_exp(1'b0, 2'd0, 1'b0, 0);
      check_out();

      // narrow counter saturation with lock held through an error burst
      do_reset();
      for (int i = 1; i <= 6; i++) word(1'b1, 3'b000, 1'b0, st(i), 1'b0, 0);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 3);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 6);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 9);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 12);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 15);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 15);
      word(1'b1, 3'b111, 1'b0, 2'd2, 1'b1, 15);
      word(1'b1, 3'b011, 1'b1, 2'd2, 1'b1, 2);
      word(1'b1, 3'b000, 1'b1, 2'd2, 1'b0, 0);
      word(1'b1, 3'b000, 1'b0, 2'd2, 1'b0, 0);
      word(1'b1, 3'b100, 1'b0, 2'd2, 1'b1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
